// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: sequences each instruction through
// FETCH -> DECODE -> EXEC [-> MEM] [-> WB] and back to FETCH, and counts
// retired instructions.
//
// Ports
//   CLK, nRST          clock (rising edge) / async active-low reset
//   opcode, funct      instruction-register fields, sampled in DECODE
//   ihit, dhit         instruction / data memory completion strobes
//   iREN, IRWr, PcWr   fetch request, IR load pulse, PC update pulse
//   RegDst .. ExtOp    datapath controls decoded from the latched opcode/funct
//   Halt, Timeout      sticky halted / fault (memory timeout or illegal opcode)
//   instr_cnt          retired-instruction count (wraps)
module multicycle_control_unit #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             ihit,
  input  logic             dhit,
  output logic             iREN,
  output logic             IRWr,
  output logic             PcWr,
  output logic             RegDst,
  output logic             RegWr,
  output logic             PcToReg,
  output logic             ImmToReg,
  output logic             MemToReg,
  output logic             DatRead,
  output logic             DatWrite,
  output logic             AluSrc,
  output logic             BrEq,
  output logic             BrNeq,
  output logic             Jump,
  output logic             Jr,
  output logic             ExtOp,
  output logic             Halt,
  output logic             Timeout,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J     = 6'b000010,
                         OP_JAL   = 6'b000011, OP_BEQ   = 6'b000100,
                         OP_BNE   = 6'b000101, OP_ADDI  = 6'b001000,
                         OP_ADDIU = 6'b001001, OP_SLTI  = 6'b001010,
                         OP_SLTIU = 6'b001011, OP_ANDI  = 6'b001100,
                         OP_ORI   = 6'b001101, OP_XORI  = 6'b001110,
                         OP_LUI   = 6'b001111, OP_LW    = 6'b100011,
                         OP_SW    = 6'b101011, OP_HALT  = 6'b111111;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // A zero-width counter is illegal, so WAIT_MAX=0 keeps a 1-bit dummy.
  localparam int WW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALTED, FAULT} state_t;

  state_t            state_q, state_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [5:0]        op_q, op_d, funct_q, funct_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic op_legal, wait_tmo, is_lw, is_sw, is_jr, is_ctrl;

  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  // The miss that would bring the counter to WAIT_MAX faults; a hit in that
  // same cycle takes priority because hit is tested first below.
  assign wait_tmo = (WAIT_MAX != 0) && (wait_q == WAIT_LAST);
  assign is_lw    = (op_q == OP_LW);
  assign is_sw    = (op_q == OP_SW);
  assign is_jr    = (op_q == OP_RTYPE) && (funct_q == FN_JR);
  assign is_ctrl  = (op_q == OP_J) || (op_q == OP_JAL) || (op_q == OP_BEQ) ||
                    (op_q == OP_BNE) || is_jr;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    op_d    = op_q;
    funct_d = funct_q;
    iREN    = 1'b0;
    IRWr    = 1'b0;
    PcWr    = 1'b0;
    RegWr   = 1'b0;
    case (state_q)
      FETCH: begin
        iREN = 1'b1;
        if (ihit) begin
          IRWr    = 1'b1;
          state_d = DECODE;
        end else if (wait_tmo) state_d = FAULT;
        else wait_d = wait_q + 1'b1;
      end
      DECODE: begin
        op_d    = opcode;
        funct_d = funct;
        if (opcode == OP_HALT) state_d = HALTED;
        else if (!op_legal)    state_d = FAULT;
        else                   state_d = EXEC;
      end
      EXEC: begin
        if (is_ctrl) begin
          PcWr    = 1'b1;
          RegWr   = (op_q == OP_JAL);
          state_d = FETCH;
          wait_d  = '0;
        end else if (is_lw || is_sw) begin
          state_d = MEM;
          wait_d  = '0;
        end else state_d = WB;
      end
      MEM: begin
        if (dhit) begin
          if (is_sw) begin
            PcWr    = 1'b1;
            state_d = FETCH;
            wait_d  = '0;
          end else state_d = WB;
        end else if (wait_tmo) state_d = FAULT;
        else wait_d = wait_q + 1'b1;
      end
      WB: begin
        RegWr   = 1'b1;
        PcWr    = 1'b1;
        state_d = FETCH;
        wait_d  = '0;
      end
      default: ;  // HALTED / FAULT are terminal until reset
    endcase
    // PcWr is never raised in HALTED/FAULT, so the count freezes there.
    cnt_d = PcWr ? cnt_q + 1'b1 : cnt_q;
  end

  // Decoded datapath controls, only driven while an instruction executes.
  logic dec_en;
  assign dec_en = (state_q == EXEC) || (state_q == MEM) || (state_q == WB);

  always_comb begin
    RegDst   = dec_en && (op_q == OP_RTYPE);
    AluSrc   = dec_en && ((op_q == OP_ADDI) || (op_q == OP_ADDIU) ||
                          (op_q == OP_SLTI) || (op_q == OP_SLTIU) ||
                          (op_q == OP_ANDI) || (op_q == OP_ORI)   ||
                          (op_q == OP_XORI) || (op_q == OP_LUI)   || is_lw || is_sw);
    ExtOp    = dec_en && ((op_q == OP_ADDI) || (op_q == OP_ADDIU) ||
                          (op_q == OP_SLTI) || (op_q == OP_SLTIU) || is_lw || is_sw ||
                          (op_q == OP_BEQ)  || (op_q == OP_BNE));
    ImmToReg = dec_en && (op_q == OP_LUI);
    MemToReg = dec_en && is_lw;
    PcToReg  = dec_en && (op_q == OP_JAL);
    Jump     = dec_en && ((op_q == OP_J) || (op_q == OP_JAL));
    Jr       = dec_en && is_jr;
    BrEq     = dec_en && (op_q == OP_BEQ);
    BrNeq    = dec_en && (op_q == OP_BNE);
    DatRead  = (state_q == MEM) && is_lw;
    DatWrite = (state_q == MEM) && is_sw;
  end

  assign Halt      = (state_q == HALTED);
  assign Timeout   = (state_q == FAULT);
  assign instr_cnt = cnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= FETCH;
      wait_q  <= '0;
      op_q    <= '0;
      funct_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      op_q    <= op_d;
      funct_q <= funct_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (WAIT_MAX=4, CNT_W=3 so both
// the timeout and the counter wrap are reachable in a few cycles).
module tb_multicycle_control_unit;

  logic       CLK = 1'b0;
  logic       nRST = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic       ihit = 1'b0, dhit = 1'b0;
  logic iREN, IRWr, PcWr, RegDst, RegWr, PcToReg, ImmToReg, MemToReg, DatRead,
        DatWrite, AluSrc, BrEq, BrNeq, Jump, Jr, ExtOp, Halt, Timeout;
  logic [2:0] instr_cnt;

  int errors = 0;
  int checks = 0;

  multicycle_control_unit #(.WAIT_MAX(4), .CNT_W(3)) dut (
    .CLK(CLK), .nRST(nRST), .opcode(opcode), .funct(funct), .ihit(ihit), .dhit(dhit),
    .iREN(iREN), .IRWr(IRWr), .PcWr(PcWr), .RegDst(RegDst), .RegWr(RegWr),
    .PcToReg(PcToReg), .ImmToReg(ImmToReg), .MemToReg(MemToReg), .DatRead(DatRead),
    .DatWrite(DatWrite), .AluSrc(AluSrc), .BrEq(BrEq), .BrNeq(BrNeq), .Jump(Jump),
    .Jr(Jr), .ExtOp(ExtOp), .Halt(Halt), .Timeout(Timeout), .instr_cnt(instr_cnt)
  );

  always #5 CLK = ~CLK;

  localparam logic [17:0] IREN = 18'h20000, IRWR = 18'h10000, PCWR = 18'h08000,
                          RDST = 18'h04000, RGWR = 18'h02000, PC2R = 18'h01000,
                          IM2R = 18'h00800, MM2R = 18'h00400, DRD  = 18'h00200,
                          DWR  = 18'h00100, ASRC = 18'h00080, BEQ  = 18'h00040,
                          BNE  = 18'h00020, JMP  = 18'h00010, JR   = 18'h00008,
                          EXT  = 18'h00004, HLT  = 18'h00002, TMO  = 18'h00001;

  logic [17:0] outs;
  assign outs = {iREN, IRWr, PcWr, RegDst, RegWr, PcToReg, ImmToReg, MemToReg,
                 DatRead, DatWrite, AluSrc, BrEq, BrNeq, Jump, Jr, ExtOp, Halt, Timeout};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Called just after a rising edge: drive hits, check this cycle's outputs,
  // then advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic ih, input logic dh, input logic [17:0] exp);
    ihit = ih;
    dhit = dh;
    #1;
    chk(tag, 32'(outs), 32'(exp));
    @(posedge CLK);
    #1;
    ihit = 1'b0;
    dhit = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    nRST = 1'b0;
    #1;
    chk(tag, 32'(outs), 32'(IREN));
    chk({tag, "_cnt"}, 32'(instr_cnt), 32'd0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  task automatic set_op(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask

  initial begin
    #1;
    do_reset("reset");

    // ADDU
    set_op(6'b000000, 6'b100001);
    cyc("addu_f", 1, 0, IREN | IRWR);
    cyc("addu_d", 0, 0, 18'h0);
    cyc("addu_e", 0, 0, RDST);
    cyc("addu_w", 0, 0, RDST | RGWR | PCWR);
    chk("addu_cnt", 32'(instr_cnt), 32'd1);

    // LW, dhit on third MEM cycle
    set_op(6'b100011, 6'b0);
    cyc("lw_f", 1, 0, IREN | IRWR);
    cyc("lw_d", 0, 0, 18'h0);
    cyc("lw_e", 0, 0, ASRC | EXT | MM2R);
    cyc("lw_m1", 0, 0, DRD | ASRC | EXT | MM2R);
    cyc("lw_m2", 0, 0, DRD | ASRC | EXT | MM2R);
    cyc("lw_m3", 0, 1, DRD | ASRC | EXT | MM2R);
    cyc("lw_w", 0, 0, ASRC | EXT | MM2R | RGWR | PCWR);
    chk("lw_cnt", 32'(instr_cnt), 32'd2);

    // JAL
    set_op(6'b000011, 6'b0);
    cyc("jal_f", 1, 0, IREN | IRWR);
    cyc("jal_d", 0, 0, 18'h0);
    cyc("jal_e", 0, 0, PC2R | JMP | RGWR | PCWR);
    chk("jal_cnt", 32'(instr_cnt), 32'd3);

    // BNE
    set_op(6'b000101, 6'b0);
    cyc("bne_f", 1, 0, IREN | IRWR);
    cyc("bne_d", 0, 0, 18'h0);
    cyc("bne_e", 0, 0, BNE | EXT | PCWR);

    // JR
    set_op(6'b000000, 6'b001000);
    cyc("jr_f", 1, 0, IREN | IRWR);
    cyc("jr_d", 0, 0, 18'h0);
    cyc("jr_e", 0, 0, RDST | JR | PCWR);

    // SW, dhit on first MEM cycle
    set_op(6'b101011, 6'b0);
    cyc("sw_f", 1, 0, IREN | IRWR);
    cyc("sw_d", 0, 0, 18'h0);
    cyc("sw_e", 0, 0, ASRC | EXT);
    cyc("sw_m", 0, 1, DWR | ASRC | EXT | PCWR);
    chk("sw_cnt", 32'(instr_cnt), 32'd6);

    // LUI
    set_op(6'b001111, 6'b0);
    cyc("lui_f", 1, 0, IREN | IRWR);
    cyc("lui_d", 0, 0, 18'h0);
    cyc("lui_e", 0, 0, ASRC | IM2R);
    cyc("lui_w", 0, 0, ASRC | IM2R | RGWR | PCWR);
    chk("lui_cnt", 32'(instr_cnt), 32'd7);

    // BEQ: eighth retirement wraps the 3-bit counter
    set_op(6'b000100, 6'b0);
    cyc("beq_f", 1, 0, IREN | IRWR);
    cyc("beq_d", 0, 0, 18'h0);
    cyc("beq_e", 0, 0, BEQ | EXT | PCWR);
    chk("wrap_cnt", 32'(instr_cnt), 32'd0);

    // ORI (zero-extended)
    set_op(6'b001101, 6'b0);
    cyc("ori_f", 1, 0, IREN | IRWR);
    cyc("ori_d", 0, 0, 18'h0);
    cyc("ori_e", 0, 0, ASRC);
    cyc("ori_w", 0, 0, ASRC | RGWR | PCWR);

    // ADDIU, ihit on the 4th FETCH cycle: hit beats timeout
    set_op(6'b001001, 6'b0);
    cyc("late_f1", 0, 0, IREN);
    cyc("late_f2", 0, 0, IREN);
    cyc("late_f3", 0, 0, IREN);
    cyc("late_f4", 1, 0, IREN | IRWR);
    cyc("late_d", 0, 0, 18'h0);
    cyc("late_e", 0, 0, ASRC | EXT);
    cyc("late_w", 0, 0, ASRC | EXT | RGWR | PCWR);
    chk("late_cnt", 32'(instr_cnt), 32'd2);

    // Fetch timeout: 4 missed cycles -> FAULT, sticky
    cyc("tmo_f1", 0, 0, IREN);
    cyc("tmo_f2", 0, 0, IREN);
    cyc("tmo_f3", 0, 0, IREN);
    cyc("tmo_f4", 0, 0, IREN);
    cyc("tmo_fault", 1, 0, TMO);
    cyc("tmo_sticky", 1, 1, TMO);
    chk("tmo_cnt", 32'(instr_cnt), 32'd2);
    do_reset("reset2");

    // Illegal opcode
    set_op(6'b010000, 6'b0);
    cyc("ill_f", 1, 0, IREN | IRWR);
    cyc("ill_d", 0, 0, 18'h0);
    cyc("ill_fault", 0, 0, TMO);
    do_reset("reset3");

    // Data timeout on LW
    set_op(6'b100011, 6'b0);
    cyc("dtmo_f", 1, 0, IREN | IRWR);
    cyc("dtmo_d", 0, 0, 18'h0);
    cyc("dtmo_e", 0, 0, ASRC | EXT | MM2R);
    cyc("dtmo_m1", 0, 0, DRD | ASRC | EXT | MM2R);
    cyc("dtmo_m2", 0, 0, DRD | ASRC | EXT | MM2R);
    cyc("dtmo_m3", 0, 0, DRD | ASRC | EXT | MM2R);
    cyc("dtmo_m4", 0, 0, DRD | ASRC | EXT | MM2R);
    cyc("dtmo_fault", 0, 1, TMO);
    do_reset("reset4");

    // One ADDU, then SW aborted by reset in MEM
    set_op(6'b000000, 6'b100001);
    cyc("pre_f", 1, 0, IREN | IRWR);
    cyc("pre_d", 0, 0, 18'h0);
    cyc("pre_e", 0, 0, RDST);
    cyc("pre_w", 0, 0, RDST | RGWR | PCWR);
    set_op(6'b101011, 6'b0);
    cyc("swr_f", 1, 0, IREN | IRWR);
    cyc("swr_d", 0, 0, 18'h0);
    cyc("swr_e", 0, 0, ASRC | EXT);
    chk("swr_precnt", 32'(instr_cnt), 32'd1);
    #1;
    chk("swr_m", 32'(outs), 32'(DWR | ASRC | EXT));
    dhit = 1'b1;
    do_reset("swr_abort");
    dhit = 1'b0;
    cyc("swr_after", 0, 0, IREN);
    chk("swr_cnt", 32'(instr_cnt), 32'd0);

    // ADDU then HALT: Halt sticky, count frozen
    set_op(6'b000000, 6'b100001);
    cyc("h0_f", 1, 0, IREN | IRWR);
    cyc("h0_d", 0, 0, 18'h0);
    cyc("h0_e", 0, 0, RDST);
    cyc("h0_w", 0, 0, RDST | RGWR | PCWR);
    set_op(6'b111111, 6'b0);
    cyc("halt_f", 1, 0, IREN | IRWR);
    cyc("halt_d", 0, 0, 18'h0);
    cyc("halt_1", 1, 1, HLT);
    cyc("halt_2", 1, 0, HLT);
    chk("halt_cnt", 32'(instr_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
